// File: rtl/dmem_port_arbiter_if.sv
// ============================================================================
//  Module      : dmem_port_arbiter_if
//  Description : Bundles the core MEM-stage port, the host read port and the
//                data-memory port that meet at the data-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_port_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int MEM_AW = 11
);
  // Core (MEM stage) port
  logic              core_req_i;
  logic              core_we_i;
  logic [XLEN-1:0]   core_addr_i;
  logic [XLEN-1:0]   core_wdata_i;
  logic              core_stall_o;
  logic              core_rvalid_o;
  logic [XLEN-1:0]   core_rdata_o;

  // Host / debug read port
  logic              dbg_req_i;
  logic [XLEN-1:0]   dbg_addr_i;
  logic              dbg_gnt_o;
  logic              dbg_rvalid_o;
  logic [XLEN-1:0]   dbg_rdata_o;

  // Data memory port
  logic              mem_en_o;
  logic              mem_we_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [XLEN-1:0]   mem_wdata_o;
  logic [XLEN-1:0]   mem_rdata_i;

  // Arbiter side: consumes requests and memory data, drives grants and strobes
  modport slave (
    input  core_req_i, core_we_i, core_addr_i, core_wdata_i,
    output core_stall_o, core_rvalid_o, core_rdata_o,
    input  dbg_req_i, dbg_addr_i,
    output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  // Environment side: pipeline, host and memory model
  modport master (
    output core_req_i, core_we_i, core_addr_i, core_wdata_i,
    input  core_stall_o, core_rvalid_o, core_rdata_o,
    output dbg_req_i, dbg_addr_i,
    input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
//  Module      : dmem_port_arbiter
//  Description : Shares a single-port synchronous-read data memory between the
//                core MEM stage and the host read port. The core has priority
//                except when the host has waited STARVE_LIMIT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int MEM_AW       = 11,
  parameter int STARVE_LIMIT = 4
) (
  input  wire                     clk_i,
  input  wire                     rst_i,
  dmem_port_arbiter_if.slave      bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_CORE = 2'd1,
    ST_RD_DBG  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt;

  logic             w_dbg_win;
  logic             w_core_win;

  // Only the word-address bits reach the memory; the rest are dropped on purpose.
  logic w_unused;
  assign w_unused = ^{bus.core_addr_i[XLEN-1:MEM_AW+2], bus.core_addr_i[1:0],
                      bus.dbg_addr_i[XLEN-1:MEM_AW+2],  bus.dbg_addr_i[1:0]};

  // Host wins when the core is quiet or the host has been starved long enough.
  always_comb begin
    w_dbg_win  = 1'b0;
    w_core_win = 1'b0;
    if (r_state == ST_IDLE) begin
      w_dbg_win  = bus.dbg_req_i && (!bus.core_req_i || (r_starve_cnt == C_STARVE_MAX));
      w_core_win = !w_dbg_win && bus.core_req_i;
    end
  end

  // State register; reset also aborts any read in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and all outputs; everything is forced to 0 while in reset.
  always_comb begin
    w_state_nxt       = r_state;
    bus.core_stall_o  = 1'b0;
    bus.core_rvalid_o = 1'b0;
    bus.core_rdata_o  = '0;
    bus.dbg_gnt_o     = 1'b0;
    bus.dbg_rvalid_o  = 1'b0;
    bus.dbg_rdata_o   = '0;
    bus.mem_en_o      = 1'b0;
    bus.mem_we_o      = 1'b0;
    bus.mem_addr_o    = '0;
    bus.mem_wdata_o   = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_dbg_win) begin
          bus.dbg_gnt_o    = 1'b1;
          bus.mem_en_o     = 1'b1;
          bus.mem_addr_o   = bus.dbg_addr_i[MEM_AW+1:2];
          bus.core_stall_o = bus.core_req_i;
          w_state_nxt      = ST_RD_DBG;
        end else if (w_core_win) begin
          bus.mem_en_o   = 1'b1;
          bus.mem_addr_o = bus.core_addr_i[MEM_AW+1:2];
          if (bus.core_we_i) begin
            bus.mem_we_o    = 1'b1;
            bus.mem_wdata_o = bus.core_wdata_i;
          end else begin
            bus.core_stall_o = 1'b1;
            w_state_nxt      = ST_RD_CORE;
          end
        end
      end
      ST_RD_CORE: begin
        // The core request seen here is the one completing, not a new one.
        bus.core_rvalid_o = 1'b1;
        bus.core_rdata_o  = bus.mem_rdata_i;
        w_state_nxt       = ST_IDLE;
      end
      ST_RD_DBG: begin
        bus.dbg_rvalid_o = 1'b1;
        bus.dbg_rdata_o  = bus.mem_rdata_i;
        bus.core_stall_o = bus.core_req_i;
        w_state_nxt      = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (rst_i) begin
      w_state_nxt       = ST_IDLE;
      bus.core_stall_o  = 1'b0;
      bus.core_rvalid_o = 1'b0;
      bus.core_rdata_o  = '0;
      bus.dbg_gnt_o     = 1'b0;
      bus.dbg_rvalid_o  = 1'b0;
      bus.dbg_rdata_o   = '0;
      bus.mem_en_o      = 1'b0;
      bus.mem_we_o      = 1'b0;
      bus.mem_addr_o    = '0;
      bus.mem_wdata_o   = '0;
    end
  end

  // Count consecutive cycles the host is kept waiting, saturating at the limit.
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.dbg_gnt_o || !bus.dbg_req_i) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != C_STARVE_MAX) begin
      r_starve_cnt <= r_starve_cnt + C_CNT_ONE;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
//  Module      : tb_dmem_port_arbiter
//  Description : Directed self-checking bench for dmem_port_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

  localparam int XLEN         = 32;
  localparam int MEM_AW       = 11;
  localparam int STARVE_LIMIT = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  dmem_port_arbiter_if #(.XLEN(XLEN), .MEM_AW(MEM_AW)) bus ();

  dmem_port_arbiter #(
    .XLEN        (XLEN),
    .MEM_AW      (MEM_AW),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive new inputs shortly after the rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Sample outputs on the falling edge
  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [63:0] or_outputs();
    return {63'd0, |{bus.core_stall_o, bus.core_rvalid_o, bus.core_rdata_o,
                     bus.dbg_gnt_o, bus.dbg_rvalid_o, bus.dbg_rdata_o,
                     bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o}};
  endfunction

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    bus.core_req_i   = 1'b1;   // outputs must stay 0 during reset regardless
    bus.core_we_i    = 1'b0;
    bus.core_addr_i  = 32'h40;
    bus.core_wdata_i = '0;
    bus.dbg_req_i    = 1'b1;
    bus.dbg_addr_i   = 32'h8;
    bus.mem_rdata_i  = 32'hDEADBEEF;

    // Reset state
    next_cycle();
    sample();
    check_eq("reset_outputs", or_outputs(), 64'd0);
    next_cycle();
    sample();
    check_eq("reset_state", dut.r_state, 64'd0);
    check_eq("reset_starve", dut.r_starve_cnt, 64'd0);

    next_cycle();
    rst = 1'b0;
    bus.core_req_i = 1'b0;
    bus.dbg_req_i  = 1'b0;
    sample();
    check_eq("idle_no_access", or_outputs(), 64'd0);

    // Core store
    next_cycle();
    bus.core_req_i = 1'b1; bus.core_we_i = 1'b1;
    bus.core_addr_i = 32'h40; bus.core_wdata_i = 32'hDEADBEEF;
    sample();
    check_eq("st_en", bus.mem_en_o, 1);
    check_eq("st_we", bus.mem_we_o, 1);
    check_eq("st_addr", bus.mem_addr_o, 64'h10);
    check_eq("st_wdata", bus.mem_wdata_o, 64'hDEADBEEF);
    check_eq("st_stall", bus.core_stall_o, 0);
    next_cycle();
    bus.core_req_i = 1'b0; bus.core_we_i = 1'b0;
    sample();
    check_eq("st_state_idle", dut.r_state, 0);
    check_eq("st_after_en", bus.mem_en_o, 0);

    // Core load
    next_cycle();
    bus.core_req_i = 1'b1; bus.core_we_i = 1'b0; bus.core_addr_i = 32'h40;
    bus.mem_rdata_i = 32'h0;
    sample();
    check_eq("ld_c0_stall", bus.core_stall_o, 1);
    check_eq("ld_c0_en", bus.mem_en_o, 1);
    check_eq("ld_c0_we", bus.mem_we_o, 0);
    check_eq("ld_c0_addr", bus.mem_addr_o, 64'h10);
    next_cycle();
    bus.mem_rdata_i = 32'hDEADBEEF;
    sample();
    check_eq("ld_c1_rvalid", bus.core_rvalid_o, 1);
    check_eq("ld_c1_rdata", bus.core_rdata_o, 64'hDEADBEEF);
    check_eq("ld_c1_stall", bus.core_stall_o, 0);
    check_eq("ld_c1_en", bus.mem_en_o, 0);
    next_cycle();
    bus.core_req_i = 1'b0;
    sample();
    check_eq("ld_c2_rvalid", bus.core_rvalid_o, 0);
    check_eq("ld_c2_rdata", bus.core_rdata_o, 0);

    // Host-only read
    next_cycle();
    bus.dbg_req_i = 1'b1; bus.dbg_addr_i = 32'h8;
    bus.mem_rdata_i = 32'h0;
    sample();
    check_eq("dbg_gnt", bus.dbg_gnt_o, 1);
    check_eq("dbg_en", bus.mem_en_o, 1);
    check_eq("dbg_we", bus.mem_we_o, 0);
    check_eq("dbg_addr", bus.mem_addr_o, 64'h2);
    check_eq("dbg_rvalid_early", bus.dbg_rvalid_o, 0);
    next_cycle();
    bus.dbg_req_i = 1'b0;
    bus.mem_rdata_i = 32'h12345678;
    sample();
    check_eq("dbg_rvalid", bus.dbg_rvalid_o, 1);
    check_eq("dbg_rdata", bus.dbg_rdata_o, 64'h12345678);
    check_eq("dbg_rd_en", bus.mem_en_o, 0);
    next_cycle();
    sample();
    check_eq("dbg_rdata_zero", bus.dbg_rdata_o, 0);

    // Continuous core stores with a pending host request: forced grant on cycle 4
    next_cycle();
    bus.core_req_i = 1'b1; bus.core_we_i = 1'b1;
    bus.core_addr_i = 32'h40; bus.core_wdata_i = 32'hCAFEF00D;
    bus.dbg_req_i = 1'b1; bus.dbg_addr_i = 32'h8;
    sample();
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      check_eq($sformatf("starve_c%0d_gnt", i), bus.dbg_gnt_o, 0);
      check_eq($sformatf("starve_c%0d_core", i), {bus.mem_en_o, bus.mem_we_o, bus.core_stall_o}, 3'b110);
      next_cycle();
      sample();
    end
    check_eq("starve_c4_gnt", bus.dbg_gnt_o, 1);
    check_eq("starve_c4_stall", bus.core_stall_o, 1);
    check_eq("starve_c4_we", bus.mem_we_o, 0);
    check_eq("starve_c4_addr", bus.mem_addr_o, 64'h2);
    next_cycle();
    bus.dbg_req_i = 1'b0;
    bus.mem_rdata_i = 32'hA5A5A5A5;
    sample();
    check_eq("starve_c5_rvalid", bus.dbg_rvalid_o, 1);
    check_eq("starve_c5_rdata", bus.dbg_rdata_o, 64'hA5A5A5A5);
    check_eq("starve_c5_stall", bus.core_stall_o, 1);
    check_eq("starve_c5_en", bus.mem_en_o, 0);
    next_cycle();
    sample();
    check_eq("starve_c6_core", {bus.mem_en_o, bus.mem_we_o, bus.core_stall_o}, 3'b110);
    check_eq("starve_c6_wdata", bus.mem_wdata_o, 64'hCAFEF00D);
    check_eq("starve_c6_gnt", bus.dbg_gnt_o, 0);
    check_eq("starve_c6_cnt", dut.r_starve_cnt, 0);
    next_cycle();
    bus.core_req_i = 1'b0; bus.core_we_i = 1'b0;
    sample();

    // Reset pulsed while a core load is in RD_CORE
    next_cycle();
    bus.core_req_i = 1'b1; bus.core_we_i = 1'b0; bus.core_addr_i = 32'h44;
    sample();
    check_eq("rst_ld_stall", bus.core_stall_o, 1);
    next_cycle();
    rst = 1'b1;
    bus.mem_rdata_i = 32'h11112222;
    sample();
    check_eq("rst_rdcore_outputs", or_outputs(), 0);
    next_cycle();
    rst = 1'b0;
    bus.core_req_i = 1'b0;
    sample();
    check_eq("rst_after_rvalid", bus.core_rvalid_o, 0);
    check_eq("rst_after_outputs", or_outputs(), 0);
    next_cycle();
    bus.core_req_i = 1'b1; bus.core_addr_i = 32'h44;
    sample();
    check_eq("rst_new_ld_stall", bus.core_stall_o, 1);
    check_eq("rst_new_ld_addr", bus.mem_addr_o, 64'h11);
    next_cycle();
    bus.mem_rdata_i = 32'h33334444;
    sample();
    check_eq("rst_new_ld_rvalid", bus.core_rvalid_o, 1);
    check_eq("rst_new_ld_rdata", bus.core_rdata_o, 64'h33334444);
    check_eq("rst_new_ld_stall_off", bus.core_stall_o, 0);
    next_cycle();
    bus.core_req_i = 1'b0;
    sample();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
